// File: rtl/mem_burst_handshake.sv
// Single-port memory behind command / write-beat / read-beat valid-ready channels,
// moving incrementing bursts of 1..2**LEN_WIDTH beats with a registered read stage.
module mem_burst_handshake #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int LEN_WIDTH  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic                  wdone_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  rlast_o,
  output logic [1:0]            state_o
);

  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid and ready are both high; the sender holds its payload until then.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH:0]    cnt;
  logic [WIDTH-1:0]      mem [DEPTH];
  logic                  r_issue;
  logic                  r_fire;
  logic                  w_fire;

  // Ready flags are masked by reset so nothing handshakes while rst_i is low.
  assign cmd_ready_o = rst_i && (state == S_IDLE);
  assign wready_o    = rst_i && (state == S_WRITE);
  assign state_o     = state;

  assign w_fire    = wvalid_i && wready_o;
  assign r_fire    = rvalid_o && rready_i;
  assign r_issue   = (state == S_READ) && (!rvalid_o || rready_i) &&
                     (cnt <= {1'b0, len_q});
  assign addr_next = (cur_addr == ADDR_WIDTH'(DEPTH - 1)) ? '0
                                                          : cur_addr + ADDR_WIDTH'(1);

  // Storage is never reset; beats already written survive an aborted burst.
  always_ff @(posedge clk_i) begin
    if (w_fire) begin
      mem[cur_addr] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= S_IDLE;
      cur_addr <= '0;
      len_q    <= '0;
      cnt      <= '0;
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      rlast_o  <= 1'b0;
      wdone_o  <= 1'b0;
    end else begin
      wdone_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            cur_addr <= cmd_addr_i;
            len_q    <= cmd_len_i;
            cnt      <= '0;
            state    <= cmd_wr_i ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          if (wvalid_i) begin
            cur_addr <= addr_next;
            cnt      <= cnt + (LEN_WIDTH + 1)'(1);
            if (cnt[LEN_WIDTH-1:0] == len_q) begin
              state   <= S_IDLE;
              wdone_o <= 1'b1;
            end
          end
        end
        S_READ: begin
          // cnt counts beats issued into the output stage, not beats accepted.
          if (r_issue) begin
            rdata_o  <= mem[cur_addr];
            rvalid_o <= 1'b1;
            rlast_o  <= (cnt == {1'b0, len_q});
            cur_addr <= addr_next;
            cnt      <= cnt + (LEN_WIDTH + 1)'(1);
          end else if (r_fire) begin
            rvalid_o <= 1'b0;
            if (rlast_o) begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_handshake.sv
// Randomised bench for mem_burst_handshake: a word-array memory model feeds an
// expected-beat queue that a negedge monitor drains on every read handshake.
module tb_mem_burst_handshake;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_wr = 1'b0;
  logic [5:0]   cmd_addr = '0;
  logic [2:0]   cmd_len = '0;
  logic         wvalid = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         rready = 1'b0;
  logic         cmd_ready_o, wready_o, wdone_o, rvalid_o, rlast_o;
  logic [W-1:0] rdata_o;
  logic [1:0]   state_o;

  mem_burst_handshake dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wvalid_i(wvalid), .wready_o(wready_o), .wdata_i(wdata), .wdone_o(wdone_o),
    .rvalid_o(rvalid_o), .rready_i(rready), .rdata_o(rdata_o), .rlast_o(rlast_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           passes = 0;
  int           cyc = 0;
  logic [W:0]   exp_q[$];
  logic [W-1:0] ref_mem [64];
  logic [W-1:0] wbuf [8];
  int           pop_cnt = 0;
  int           first_hs = 0;
  int           last_hs = 0;
  int           wdone_seen = 0;
  int           exp_wdone = 0;
  logic         hold_prev = 1'b0;
  logic [W:0]   prev_beat = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else passes++;
  endtask

  always @(posedge clk) cyc++;

  // Monitor: beat ordering, hold-under-backpressure, wdone pulse count.
  always @(negedge clk) begin
    logic [W:0] e;
    if (wdone_o === 1'b1) wdone_seen++;
    if (hold_prev) check("r_hold", {rvalid_o, rlast_o, rdata_o}, {1'b1, prev_beat});
    hold_prev = (rvalid_o === 1'b1) && !rready;
    prev_beat = {rlast_o, rdata_o};
    if (rvalid_o === 1'b1 && rready) begin
      if (exp_q.size() == 0) begin
        check("r_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("r_beat", {rlast_o, rdata_o}, e);
        if (pop_cnt == 0) first_hs = cyc;
        last_hs = cyc;
        pop_cnt++;
      end
    end
  end

  // Returns at 1 time unit after the accepting edge.
  task automatic send_cmd(input logic wr, input int addr, input int len);
    logic r;
    int   t;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = 6'(addr); cmd_len = 3'(len);
    r = 1'b0; t = 0;
    while (!r && t < 200) begin
      @(negedge clk); r = cmd_ready_o;
      @(posedge clk); t++;
    end
    #1;
    cmd_valid = 1'b0;
    if (!r) check("cmd_timeout", 32'd0, 32'd1);
  endtask

  task automatic write_beat(input int addr, input logic [W-1:0] d);
    logic r;
    int   t;
    wvalid = 1'b1; wdata = d;
    r = 1'b0; t = 0;
    while (!r && t < 200) begin
      @(negedge clk); r = wready_o;
      @(posedge clk); t++;
    end
    #1;
    if (!r) check("w_timeout", 32'd0, 32'd1);
    else ref_mem[addr % 64] = d;
  endtask

  task automatic write_burst(input int addr, input int len, input int gap);
    send_cmd(1'b1, addr, len);
    for (int i = 0; i <= len; i++) begin
      for (int g = 0; g < gap; g++) begin
        wvalid = 1'b0; wdata = W'($urandom_range(0, 16'hffff));
        @(negedge clk); check("wready_stall", wready_o, 1'b1);
        @(posedge clk); #1;
      end
      write_beat(addr + i, wbuf[i]);
    end
    wvalid = 1'b0;
    @(negedge clk); check("wdone_pulse", wdone_o, 1'b1);
    exp_wdone++;
  endtask

  // mode 0: rready held high, 1: random rready, 2: 3-cycle stall on beat 2.
  task automatic read_burst(input int addr, input int len, input int mode, input logic lat_chk);
    int t;
    int stall;
    for (int i = 0; i <= len; i++)
      exp_q.push_back({(i == len), ref_mem[(addr + i) % 64]});
    pop_cnt = 0; stall = 3; t = 0;
    send_cmd(1'b0, addr, len);
    while (exp_q.size() > 0 && t < 200) begin
      if (mode == 1) rready = 1'($urandom_range(0, 1));
      else if (mode == 2 && pop_cnt == 1 && stall > 0 && rvalid_o) begin
        rready = 1'b0; stall--;
      end else rready = 1'b1;
      @(negedge clk);
      if (lat_chk && t == 0) check("r_latency_n", rvalid_o, 1'b0);
      if (lat_chk && t == 1) check("r_latency_n1", rvalid_o, 1'b1);
      @(posedge clk); #1; t++;
    end
    rready = 1'b0;
    check("r_drained", exp_q.size(), 32'd0);
    if (mode == 0) check("r_back_to_back", last_hs - first_hs, len);
    if (mode == 2) check("r_beat_count", pop_cnt, len + 1);
  endtask

  initial begin
    int wr, a, l;
    // Reset with random inputs on the buses.
    for (int i = 0; i < 2; i++) begin
      cmd_valid = 1'($urandom_range(0, 1)); cmd_wr = 1'($urandom_range(0, 1));
      cmd_addr = 6'($urandom_range(0, 63)); wvalid = 1'($urandom_range(0, 1));
      rready = 1'($urandom_range(0, 1));
      @(posedge clk); @(negedge clk);
      check("rst_cmd_ready", cmd_ready_o, 1'b0);
      check("rst_rvalid", rvalid_o, 1'b0);
      check("rst_wready", wready_o, 1'b0);
    end
    #1; rst = 1'b1; cmd_valid = 1'b0; wvalid = 1'b0; rready = 1'b0;
    @(negedge clk); check("rst_release_ready", cmd_ready_o, 1'b1);
    check("rst_wdone", wdone_o, 1'b0);

    // Fill every word so later readbacks have known contents.
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 8; i++) wbuf[i] = W'($urandom_range(0, 16'hffff));
      write_burst(b * 8, 7, 0);
    end

    // Single beat.
    wbuf[0] = 16'ha5a5;
    write_burst(5, 0, 0);
    read_burst(5, 0, 0, 1'b1);

    // Full burst across the top of memory.
    for (int i = 0; i < 8; i++) wbuf[i] = W'(16'h0100 + i);
    write_burst(62, 7, 0);
    read_burst(62, 7, 0, 1'b0);

    // Backpressure on beat 2.
    read_burst(62, 3, 2, 1'b0);

    // Write gaps.
    for (int i = 0; i < 4; i++) wbuf[i] = W'($urandom_range(0, 16'hffff));
    write_burst(40, 3, 2);
    read_burst(40, 3, 1, 1'b0);

    // Reset after two beats of an eight-beat write.
    send_cmd(1'b1, 20, 7);
    write_beat(20, 16'hbee0);
    write_beat(21, 16'hbee1);
    rst = 1'b0; wvalid = 1'b1; wdata = 16'hdead;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_mid_wready", wready_o, 1'b0);
      check("rst_mid_cmd_ready", cmd_ready_o, 1'b0);
      @(posedge clk);
    end
    #1; rst = 1'b1; wvalid = 1'b0;
    @(negedge clk); check("rst_mid_idle", cmd_ready_o, 1'b1);
    read_burst(20, 7, 0, 1'b0);

    // Random mix.
    for (int k = 0; k < 24; k++) begin
      wr = $urandom_range(0, 1); a = $urandom_range(0, 63); l = $urandom_range(0, 7);
      if (wr == 1) begin
        for (int i = 0; i < 8; i++) wbuf[i] = W'($urandom_range(0, 16'hffff));
        write_burst(a, l, $urandom_range(0, 2));
      end else begin
        read_burst(a, l, $urandom_range(0, 1), 1'b0);
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("wdone_total", wdone_seen, exp_wdone);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
